// File: rtl/vme_cmd_arbiter.sv
// Round-robin arbiter that shares the single VME command port among NREQ
// requesters, formats the command word and aborts stalled accesses on timeout.
module vme_cmd_arbiter #(
   parameter int          NREQ    = 2,
   parameter int          TIMEOUT = 255,
   parameter logic [31:0] MASK    = 32'h00A80000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ-1:0]      req_rd,
   input  logic [16*NREQ-1:0]   req_addr,
   input  logic [16*NREQ-1:0]   req_wdata,
   output logic [NREQ-1:0]      gnt,
   output logic [NREQ-1:0]      done,
   output logic [15:0]          rdata,
   output logic                 err,
   input  logic                 vme_cmd_rd,
   output logic                 start,
   output logic [31:0]          vme_cmd_reg,
   output logic [31:0]          vme_dat_reg_in,
   input  logic                 vme_dat_wr,
   input  logic [31:0]          vme_dat_reg_out
);

   localparam int              PW       = (NREQ > 2) ? 2 : 1;
   localparam logic [15:0]     CNT_LAST = 16'(TIMEOUT - 1);
   localparam logic [31:0]     RD_BIT   = 32'h0200_0000;
   localparam logic [31:0]     WR_BIT   = 32'h0100_0000;
   localparam logic [NREQ-1:0] ONE      = {{(NREQ-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t         state, state_nx;
   logic [PW-1:0]  ptr, ptr_nx, cur, cur_nx, win;
   logic           cur_rd, cur_rd_nx, win_rd;
   logic [15:0]    cnt, cnt_nx, win_addr, win_wdata, rdata_nx;
   logic [NREQ-1:0] gnt_nx, done_nx;
   logic           start_nx, err_nx;
   logic [31:0]    cmd_nx, wdat_nx;
   int             cand;
   logic           unused_hi;

   assign unused_hi = ^vme_dat_reg_out[31:16];

   // Round-robin pick: scan downward so the nearest requester after ptr wins last.
   always_comb begin
      win  = ptr;
      cand = 0;
      for (int k = NREQ; k >= 1; k--) begin
         cand = int'(ptr) + k;
         if (cand >= NREQ) cand = cand - NREQ;
         if ((req & (ONE << cand)) != '0) win = PW'(cand);
      end
      win_rd    = |(req_rd & (ONE << win));
      win_addr  = 16'(req_addr >> (16 * int'(win)));
      win_wdata = 16'(req_wdata >> (16 * int'(win)));
   end

   always_comb begin
      state_nx  = state;
      ptr_nx    = ptr;
      cur_nx    = cur;
      cur_rd_nx = cur_rd;
      cnt_nx    = cnt;
      start_nx  = 1'b0;
      gnt_nx    = '0;
      done_nx   = '0;
      err_nx    = 1'b0;
      rdata_nx  = rdata;
      cmd_nx    = vme_cmd_reg;
      wdat_nx   = vme_dat_reg_in;
      case (state)
         IDLE: begin
            cmd_nx  = MASK;
            wdat_nx = '0;
            if (vme_cmd_rd && (req != '0)) begin
               ptr_nx    = win;
               cur_nx    = win;
               cur_rd_nx = win_rd;
               start_nx  = 1'b1;
               gnt_nx    = ONE << win;
               cmd_nx    = MASK | {16'h0, win_addr} | (win_rd ? RD_BIT : WR_BIT);
               wdat_nx   = win_rd ? 32'h0 : {16'h0, win_wdata};
               state_nx  = ISSUE;
            end
         end
         ISSUE: begin
            cnt_nx   = '0;
            state_nx = WAIT;
         end
         WAIT: begin
            // A completion strobe beats a timeout landing in the same cycle.
            if (vme_dat_wr) begin
               done_nx  = ONE << cur;
               if (cur_rd) rdata_nx = vme_dat_reg_out[15:0];
               cmd_nx   = MASK;
               wdat_nx  = '0;
               state_nx = IDLE;
            end else if (cnt == CNT_LAST) begin
               done_nx  = ONE << cur;
               err_nx   = 1'b1;
               if (cur_rd) rdata_nx = 16'hDEAD;
               cmd_nx   = MASK;
               wdat_nx  = '0;
               state_nx = IDLE;
            end else begin
               cnt_nx = cnt + 16'd1;
            end
         end
         default: begin
            cmd_nx   = MASK;
            wdat_nx  = '0;
            state_nx = IDLE;
         end
      endcase
   end

   // All port outputs come straight from flops; reset abandons any access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         ptr            <= PW'(NREQ - 1);
         cur            <= '0;
         cur_rd         <= 1'b0;
         cnt            <= '0;
         start          <= 1'b0;
         gnt            <= '0;
         done           <= '0;
         err            <= 1'b0;
         rdata          <= '0;
         vme_cmd_reg    <= MASK;
         vme_dat_reg_in <= '0;
      end else begin
         state          <= state_nx;
         ptr            <= ptr_nx;
         cur            <= cur_nx;
         cur_rd         <= cur_rd_nx;
         cnt            <= cnt_nx;
         start          <= start_nx;
         gnt            <= gnt_nx;
         done           <= done_nx;
         err            <= err_nx;
         rdata          <= rdata_nx;
         vme_cmd_reg    <= cmd_nx;
         vme_dat_reg_in <= wdat_nx;
      end
   end

endmodule

// File: tb/tb_vme_cmd_arbiter.sv
// Directed self-checking bench for vme_cmd_arbiter (NREQ=2, TIMEOUT=8).
module tb_vme_cmd_arbiter;

   localparam logic [31:0] MASK = 32'h00A80000;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req, req_rd, gnt, done;
   logic [31:0] req_addr, req_wdata;
   logic [15:0] rdata;
   logic        err, vme_cmd_rd, start, vme_dat_wr;
   logic [31:0] vme_cmd_reg, vme_dat_reg_in, vme_dat_reg_out;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   vme_cmd_arbiter #(.NREQ(2), .TIMEOUT(8), .MASK(MASK)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_rd(req_rd),
      .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
      .rdata(rdata), .err(err), .vme_cmd_rd(vme_cmd_rd), .start(start),
      .vme_cmd_reg(vme_cmd_reg), .vme_dat_reg_in(vme_dat_reg_in),
      .vme_dat_wr(vme_dat_wr), .vme_dat_reg_out(vme_dat_reg_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Polls on falling edges until start rises, giving up after a budget.
   task automatic wait_start(output bit ok);
      int n;
      n = 0;
      while (start !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      ok = (start === 1'b1);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if ({start, gnt, done, err} !== 6'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_strobes: got start=%b gnt=%b done=%b err=%b, want all 0", start, gnt, done, err);
      end
      n_checks++;
      if (rdata !== 16'h0) begin
         n_fail++;
         $display("[TB] FAIL reset_rdata: got %h want 0000", rdata);
      end
      n_checks++;
      if (vme_cmd_reg !== MASK || vme_dat_reg_in !== 32'h0) begin
         n_fail++;
         $display("[TB] FAIL reset_cmd: got cmd=%h dat=%h want %h/00000000", vme_cmd_reg, vme_dat_reg_in, MASK);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_write();
      req = 2'b01; req_rd = 2'b00; req_addr[15:0] = 16'h4000; req_wdata[15:0] = 16'h1234;
      vme_cmd_rd = 1'b1;
      @(negedge clk);
      n_checks++;
      if (start !== 1'b1 || gnt !== 2'b01) begin
         n_fail++;
         $display("[TB] FAIL wr_grant: got start=%b gnt=%b want 1/01", start, gnt);
      end
      n_checks++;
      if (vme_cmd_reg !== 32'h01A84000 || vme_dat_reg_in !== 32'h00001234) begin
         n_fail++;
         $display("[TB] FAIL wr_cmd: got cmd=%h dat=%h want 01A84000/00001234", vme_cmd_reg, vme_dat_reg_in);
      end
      req = 2'b00;
      @(negedge clk);
      n_checks++;
      if (start !== 1'b0 || vme_cmd_reg !== 32'h01A84000) begin
         n_fail++;
         $display("[TB] FAIL wr_hold: got start=%b cmd=%h want 0/01A84000", start, vme_cmd_reg);
      end
      @(negedge clk);
      vme_dat_wr = 1'b1;
      @(negedge clk);
      vme_dat_wr = 1'b0;
      n_checks++;
      if (done !== 2'b01 || err !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL wr_done: got done=%b err=%b want 01/0", done, err);
      end
      n_checks++;
      if (vme_cmd_reg !== MASK || vme_dat_reg_in !== 32'h0) begin
         n_fail++;
         $display("[TB] FAIL wr_idle_cmd: got cmd=%h dat=%h want %h/0", vme_cmd_reg, vme_dat_reg_in, MASK);
      end
      @(negedge clk);
      n_checks++;
      if (done !== 2'b00) begin
         n_fail++;
         $display("[TB] FAIL wr_done_pulse: got done=%b want 00", done);
      end
   endtask

   task automatic test_single_read();
      req = 2'b10; req_rd = 2'b10; req_addr[31:16] = 16'h4100; req_wdata[31:16] = 16'h7777;
      vme_dat_reg_out = 32'h0000BEEF;
      @(negedge clk);
      n_checks++;
      if (start !== 1'b1 || gnt !== 2'b10 || vme_cmd_reg !== 32'h02A84100 || vme_dat_reg_in !== 32'h0) begin
         n_fail++;
         $display("[TB] FAIL rd_issue: got start=%b gnt=%b cmd=%h dat=%h want 1/10/02A84100/0", start, gnt, vme_cmd_reg, vme_dat_reg_in);
      end
      req = 2'b00;
      @(negedge clk);
      vme_dat_wr = 1'b1;
      @(negedge clk);
      vme_dat_wr = 1'b0;
      n_checks++;
      if (done !== 2'b10 || rdata !== 16'hBEEF || err !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL rd_done: got done=%b rdata=%h err=%b want 10/BEEF/0", done, rdata, err);
      end
      @(negedge clk);
   endtask

   task automatic test_round_robin();
      bit ok;
      int last_cyc;
      logic [1:0]  exp_gnt;
      logic [31:0] exp_cmd;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      req_rd = 2'b00;
      req_addr = {16'h2000, 16'h1000};
      req_wdata = {16'h00B2, 16'h00A1};
      req = 2'b11;
      last_cyc = 0;
      for (int t = 0; t < 4; t++) begin
         exp_gnt = (t % 2 == 0) ? 2'b01 : 2'b10;
         exp_cmd = (t % 2 == 0) ? 32'h01A81000 : 32'h01A82000;
         wait_start(ok);
         n_checks++;
         if (!ok || gnt !== exp_gnt || vme_cmd_reg !== exp_cmd) begin
            n_fail++;
            $display("[TB] FAIL rr_grant%0d: got start=%b gnt=%b cmd=%h want 1/%b/%h", t, start, gnt, vme_cmd_reg, exp_gnt, exp_cmd);
         end
         if (t > 0) begin
            n_checks++;
            if (cyc - last_cyc != 3) begin
               n_fail++;
               $display("[TB] FAIL rr_spacing%0d: got %0d cycles want 3", t, cyc - last_cyc);
            end
         end
         last_cyc = cyc;
         @(negedge clk);
         vme_dat_wr = 1'b1;
         @(negedge clk);
         vme_dat_wr = 1'b0;
         if (t == 3) req = 2'b00;
         n_checks++;
         if (done !== exp_gnt) begin
            n_fail++;
            $display("[TB] FAIL rr_done%0d: got %b want %b", t, done, exp_gnt);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_timeout();
      bit ok;
      int n;
      req = 2'b01; req_rd = 2'b01; req_addr[15:0] = 16'h4200;
      wait_start(ok);
      req = 2'b00;
      n = 0;
      while (done === 2'b00 && n < 30) begin
         @(negedge clk);
         n++;
      end
      // Eight WAIT cycles with no strobe, then the done/err cycle.
      n_checks++;
      if (n != 9 || !ok) begin
         n_fail++;
         $display("[TB] FAIL to_latency: got done %0d cycles after start want 9", n);
      end
      n_checks++;
      if (done !== 2'b01 || err !== 1'b1 || rdata !== 16'hDEAD) begin
         n_fail++;
         $display("[TB] FAIL to_abort: got done=%b err=%b rdata=%h want 01/1/DEAD", done, err, rdata);
      end
      req = 2'b10; req_rd = 2'b00; req_addr[31:16] = 16'h4400; req_wdata[31:16] = 16'hCAFE;
      wait_start(ok);
      n_checks++;
      if (!ok || gnt !== 2'b10 || vme_cmd_reg !== 32'h01A84400 || vme_dat_reg_in !== 32'h0000CAFE) begin
         n_fail++;
         $display("[TB] FAIL to_next_issue: got gnt=%b cmd=%h dat=%h want 10/01A84400/0000CAFE", gnt, vme_cmd_reg, vme_dat_reg_in);
      end
      req = 2'b00;
      @(negedge clk);
      vme_dat_wr = 1'b1;
      @(negedge clk);
      vme_dat_wr = 1'b0;
      n_checks++;
      if (done !== 2'b10 || err !== 1'b0 || rdata !== 16'hDEAD) begin
         n_fail++;
         $display("[TB] FAIL to_next_done: got done=%b err=%b rdata=%h want 10/0/DEAD", done, err, rdata);
      end
      @(negedge clk);
   endtask

   task automatic test_back_pressure();
      int bad;
      bad = 0;
      vme_cmd_rd = 1'b0;
      req = 2'b01; req_rd = 2'b00; req_addr[15:0] = 16'h4300; req_wdata[15:0] = 16'h0055;
      for (int i = 0; i < 10; i++) begin
         vme_dat_wr = (i == 5);
         @(negedge clk);
         if (start !== 1'b0 || done !== 2'b00) bad++;
      end
      vme_dat_wr = 1'b0;
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("[TB] FAIL bp_hold: got %0d cycles with start/done want 0", bad);
      end
      vme_cmd_rd = 1'b1;
      @(negedge clk);
      n_checks++;
      if (start !== 1'b1 || gnt !== 2'b01 || vme_cmd_reg !== 32'h01A84300) begin
         n_fail++;
         $display("[TB] FAIL bp_release: got start=%b gnt=%b cmd=%h want 1/01/01A84300", start, gnt, vme_cmd_reg);
      end
      req = 2'b00;
      @(negedge clk);
      vme_dat_wr = 1'b1;
      @(negedge clk);
      vme_dat_wr = 1'b0;
      n_checks++;
      if (done !== 2'b01) begin
         n_fail++;
         $display("[TB] FAIL bp_done: got %b want 01", done);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_wait();
      bit ok;
      int bad;
      req = 2'b01; req_rd = 2'b00; req_addr[15:0] = 16'h4500; req_wdata[15:0] = 16'h0099;
      wait_start(ok);
      req = 2'b00;
      @(negedge clk);
      n_checks++;
      if (!ok || vme_cmd_reg !== 32'h01A84500 || vme_dat_reg_in !== 32'h00000099) begin
         n_fail++;
         $display("[TB] FAIL rst_wait_hold: got cmd=%h dat=%h want 01A84500/00000099", vme_cmd_reg, vme_dat_reg_in);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (vme_cmd_reg !== MASK || vme_dat_reg_in !== 32'h0 || {start, gnt, done, err} !== 6'b0) begin
         n_fail++;
         $display("[TB] FAIL rst_async: got cmd=%h dat=%h start=%b gnt=%b done=%b err=%b want reset values", vme_cmd_reg, vme_dat_reg_in, start, gnt, done, err);
      end
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done !== 2'b00) bad++;
      end
      req = 2'b11; req_addr = {16'h4600, 16'h4700}; req_wdata = 32'h0;
      rst_n = 1'b1;
      @(negedge clk);
      if (done !== 2'b00) bad++;
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("[TB] FAIL rst_no_done: got %0d cycles with done want 0", bad);
      end
      wait_start(ok);
      n_checks++;
      if (!ok || gnt !== 2'b01 || vme_cmd_reg !== 32'h01A84700) begin
         n_fail++;
         $display("[TB] FAIL rst_priority: got gnt=%b cmd=%h want 01/01A84700", gnt, vme_cmd_reg);
      end
      req = 2'b00;
      @(negedge clk);
      vme_dat_wr = 1'b1;
      @(negedge clk);
      vme_dat_wr = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b1; req = '0; req_rd = '0; req_addr = '0; req_wdata = '0;
      vme_cmd_rd = 1'b0; vme_dat_wr = 1'b0; vme_dat_reg_out = '0;
      #2;
      test_reset();
      test_single_write();
      test_single_read();
      test_round_robin();
      test_timeout();
      test_back_pressure();
      test_reset_mid_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
